// File: rtl/windowed_energy_if.sv
// rtl/windowed_energy_if.sv - sample-in / energy-out bundle for the windowed energy estimator
interface windowed_energy_if #(
  parameter int DATA_W   = 16,
  parameter int CHANNELS = 4
);
  logic                             in_valid;
  logic [CHANNELS*DATA_W-1:0]       in_data;
  logic [2*DATA_W-1:0]              threshold;
  logic                             out_valid;
  logic [CHANNELS*2*DATA_W-1:0]     energy;
  logic [CHANNELS-1:0]              detect;
  logic                             window_full;

  modport master (
    output in_valid, in_data, threshold,
    input  out_valid, energy, detect, window_full
  );

  modport slave (
    input  in_valid, in_data, threshold,
    output out_valid, energy, detect, window_full
  );
endinterface

// File: rtl/windowed_energy.sv
// rtl/windowed_energy.sv - multi-channel sliding-window mean power with threshold detect
module windowed_energy #(
  parameter int DATA_W   = 16,
  parameter int CHANNELS = 4,
  parameter int WIN_LOG2 = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  windowed_energy_if.slave bus
);

  localparam int N     = 1 << WIN_LOG2;
  localparam int SQ_W  = 2 * DATA_W;
  localparam int ACC_W = SQ_W + WIN_LOG2;

  localparam logic [WIN_LOG2:0]   FILL_MAX  = (WIN_LOG2 + 1)'(N);
  localparam logic [WIN_LOG2:0]   FILL_LAST = (WIN_LOG2 + 1)'(N - 1);
  localparam logic [WIN_LOG2:0]   FILL_ONE  = (WIN_LOG2 + 1)'(1);
  localparam logic [WIN_LOG2-1:0] PTR_ONE   = WIN_LOG2'(1);

  // Square history; never reset because old_sq is masked until the window is full
  logic [SQ_W-1:0]        mem_q [CHANNELS][N];

  logic                   accept;
  logic signed [SQ_W-1:0] smp_ext [CHANNELS];
  logic [SQ_W-1:0]        sq_d    [CHANNELS];
  logic [SQ_W-1:0]        old_d   [CHANNELS];

  logic [SQ_W-1:0]        sq_q    [CHANNELS];
  logic [SQ_W-1:0]        old_q   [CHANNELS];
  logic                   v1_q;
  logic                   full1_q;
  logic [WIN_LOG2-1:0]    ptr_q;
  logic [WIN_LOG2:0]      fill_q;

  logic [ACC_W-1:0]       acc_d    [CHANNELS];
  logic [ACC_W-1:0]       acc_q    [CHANNELS];
  logic [SQ_W-1:0]        energy_d [CHANNELS];
  logic [SQ_W-1:0]        energy_q [CHANNELS];
  logic [CHANNELS-1:0]    det_d;
  logic [CHANNELS-1:0]    det_q;
  logic                   full_q;
  logic                   ov_q;

  // A sample coinciding with clear is dropped entirely
  assign accept = bus.in_valid & ~clear_i;

  // Square each channel and fetch the square leaving the window
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      smp_ext[c] = SQ_W'($signed(bus.in_data[c*DATA_W +: DATA_W]));
      sq_d[c]    = $unsigned(smp_ext[c] * smp_ext[c]);
      old_d[c]   = (fill_q == FILL_MAX) ? mem_q[c][ptr_q] : '0;
    end
  end

  // Circular buffer write at the shared pointer
  always_ff @(posedge clk_i) begin
    if (accept) begin
      for (int c = 0; c < CHANNELS; c++) begin
        mem_q[c][ptr_q] <= sq_d[c];
      end
    end
  end

  // Stage 1: register new/old squares, advance pointer and fill count
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1_q    <= 1'b0;
      full1_q <= 1'b0;
      ptr_q   <= '0;
      fill_q  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        sq_q[c]  <= '0;
        old_q[c] <= '0;
      end
    end else if (clear_i) begin
      v1_q    <= 1'b0;
      full1_q <= 1'b0;
      ptr_q   <= '0;
      fill_q  <= '0;
    end else begin
      v1_q <= bus.in_valid;
      if (bus.in_valid) begin
        for (int c = 0; c < CHANNELS; c++) begin
          sq_q[c]  <= sq_d[c];
          old_q[c] <= old_d[c];
        end
        ptr_q   <= ptr_q + PTR_ONE;
        fill_q  <= (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_ONE;
        full1_q <= (fill_q == FILL_LAST) || (fill_q == FILL_MAX);
      end
    end
  end

  // Running sum update, truncating mean and strict threshold compare
  always_comb begin
    det_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      acc_d[c]    = acc_q[c] + ACC_W'(sq_q[c]) - ACC_W'(old_q[c]);
      energy_d[c] = acc_d[c][ACC_W-1:WIN_LOG2];
      det_d[c]    = energy_d[c] > bus.threshold;
    end
  end

  // Stage 2: commit accumulators and outputs for a valid stage-1 entry
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ov_q   <= 1'b0;
      full_q <= 1'b0;
      det_q  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        acc_q[c]    <= '0;
        energy_q[c] <= '0;
      end
    end else if (clear_i) begin
      ov_q   <= 1'b0;
      full_q <= 1'b0;
      det_q  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        acc_q[c]    <= '0;
        energy_q[c] <= '0;
      end
    end else begin
      ov_q <= v1_q;
      if (v1_q) begin
        full_q <= full1_q;
        det_q  <= det_d;
        for (int c = 0; c < CHANNELS; c++) begin
          acc_q[c]    <= acc_d[c];
          energy_q[c] <= energy_d[c];
        end
      end
    end
  end

  // Pack registered results onto the output bundle
  always_comb begin
    bus.energy = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      bus.energy[c*SQ_W +: SQ_W] = energy_q[c];
    end
  end

  assign bus.out_valid   = ov_q;
  assign bus.detect      = det_q;
  assign bus.window_full = full_q;

endmodule

// File: tb/tb_windowed_energy.sv
// tb/tb_windowed_energy.sv - scoreboard bench for windowed_energy
module tb_windowed_energy;
  localparam int DW = 16;
  localparam int CH = 4;
  localparam int WL = 4;
  localparam int N  = 16;
  localparam int EW = 2 * DW;

  typedef struct packed {
    logic [CH*EW-1:0] e;
    logic [CH-1:0]    det;
    logic             full;
    int               issue;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  longint win [CH][N];
  int     wptr;
  int     fill;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  windowed_energy_if #(.DATA_W(DW), .CHANNELS(CH)) bus();

  windowed_energy #(.DATA_W(DW), .CHANNELS(CH), .WIN_LOG2(WL)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (clr),
    .bus     (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] ch_energy(input int c);
    return bus.energy[c*EW +: EW];
  endfunction

  task automatic model_clear();
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < N; i++) win[c][i] = 0;
    wptr = 0;
    fill = 0;
  endtask

  task automatic model_push(input logic signed [DW-1:0] d [CH]);
    exp_t   x;
    longint acc;
    longint en;
    x.e   = '0;
    x.det = '0;
    for (int c = 0; c < CH; c++) win[c][wptr] = longint'(d[c]) * longint'(d[c]);
    wptr = (wptr + 1) % N;
    if (fill < N) fill++;
    for (int c = 0; c < CH; c++) begin
      acc = 0;
      for (int i = 0; i < N; i++) acc += win[c][i];
      en = acc >>> WL;
      x.e[c*EW +: EW] = en[EW-1:0];
      x.det[c] = en > longint'(bus.threshold);
    end
    x.full  = (fill == N);
    x.issue = cyc;
    q.push_back(x);
  endtask

  task automatic send(input logic v, input logic signed [DW-1:0] d0, input logic signed [DW-1:0] d1,
                      input logic signed [DW-1:0] d2, input logic signed [DW-1:0] d3);
    logic signed [DW-1:0] d [CH];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    @(posedge clk); #1;
    bus.in_valid = v;
    bus.in_data  = {d3, d2, d1, d0};
    if (v) model_push(d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 0, 0, 0, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 0);
    chk({tag, "_energy"}, 64'(bus.energy), 0);
    chk({tag, "_detect"}, 64'(bus.detect), 0);
    chk({tag, "_window_full"}, 64'(bus.window_full), 0);
  endtask

  task automatic do_clear(input logic with_valid);
    @(posedge clk); #1;
    clr = 1'b1;
    bus.in_valid = with_valid;
    bus.in_data  = {4{16'sd100}};
    @(posedge clk); #1;
    clr = 1'b0;
    bus.in_valid = 1'b0;
    model_clear();
    chk_zero("clear");
  endtask

  // Monitor: compare every out_valid pulse against the oldest expectation
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got 1 expected 0 at cycle %0d", cyc);
      end else begin
        exp_t x;
        x = q.pop_front();
        chk("pulse_energy", 64'(bus.energy), 64'(x.e));
        chk("pulse_detect", 64'(bus.detect), 64'(x.det));
        chk("pulse_window_full", 64'(bus.window_full), 64'(x.full));
        chk("pulse_latency", 64'(cyc - x.issue), 2);
      end
    end
  end

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.threshold = 32'd5000;
    model_clear();
    #12;
    chk_zero("reset");
    @(posedge clk); #3;
    rst = 1'b0;

    // Fill with constant 100 on ch0
    for (int k = 0; k < N; k++) send(1'b1, 100, 0, 0, 0);
    idle(3);
    chk("fill_energy0", 64'(ch_energy(0)), 10000);
    chk("fill_full", 64'(bus.window_full), 1);

    // Decay to zero then rise with 200
    for (int k = 0; k < N; k++) send(1'b1, 0, 0, 0, 0);
    idle(3);
    chk("decay_energy0", 64'(ch_energy(0)), 0);
    for (int k = 0; k < 8; k++) send(1'b1, 200, 0, 0, 0);
    idle(3);
    chk("rise_energy0", 64'(ch_energy(0)), 20000);

    // Clear coincident with in_valid, then refill
    do_clear(1'b1);
    send(1'b1, 100, 0, 0, 0);
    idle(3);
    chk("refill_first", 64'(ch_energy(0)), 625);
    for (int k = 1; k < N; k++) send(1'b1, 100, 0, 0, 0);
    idle(3);
    chk("refill_energy0", 64'(ch_energy(0)), 10000);

    // Gaps and threshold on ch1
    do_clear(1'b0);
    bus.threshold = 32'd9999;
    for (int k = 0; k < N; k++) begin
      send(1'b1, 0, 100, 0, 0);
      idle(2);
    end
    idle(1);
    chk("gap_energy1", 64'(ch_energy(1)), 10000);
    chk("gap_detect1", 64'(bus.detect[1]), 1);
    bus.threshold = 32'd10000;
    send(1'b1, 0, 100, 0, 0);
    idle(3);
    chk("thr_eq_detect1", 64'(bus.detect[1]), 0);

    // Extremes
    do_clear(1'b0);
    for (int k = 0; k < 20; k++) send(1'b1, -32768, -32768, -32768, 32767);
    idle(3);
    chk("ext_energy0", 64'(ch_energy(0)), 64'd1073741824);
    chk("ext_energy3", 64'(ch_energy(3)), 64'd1073676289);

    // Channel independence
    do_clear(1'b0);
    for (int k = 0; k < 20; k++) send(1'b1, 100, 0, -50, (k % 2) ? -16'sd1000 : 16'sd1000);
    idle(3);
    chk("ind_energy0", 64'(ch_energy(0)), 10000);
    chk("ind_energy1", 64'(ch_energy(1)), 0);
    chk("ind_energy2", 64'(ch_energy(2)), 2500);
    chk("ind_energy3", 64'(ch_energy(3)), 1000000);

    // Async reset mid-stream aborts in-flight samples
    for (int k = 0; k < 5; k++) send(1'b1, 100, 100, 100, 100);
    #2;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    q.delete();
    model_clear();
    #1;
    chk_zero("async_reset");
    @(posedge clk); #3;
    rst = 1'b0;
    idle(3);
    chk("post_reset_quiet", 64'(bus.out_valid), 0);
    for (int k = 0; k < N; k++) send(1'b1, 100, 0, 0, 0);
    idle(3);
    chk("reset_refill_energy0", 64'(ch_energy(0)), 10000);
    chk("reset_refill_full", 64'(bus.window_full), 1);

    chk("scoreboard_drained", 64'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/windowed_energy.md
# windowed_energy

Multi-channel sliding-window signal energy estimator for the AVS acquisition chain. Each accepted sample vector updates, per channel, a running sum of squares over the last 2^WIN_LOG2 samples held in an internal circular buffer. The block outputs the window mean power and a per-channel threshold-detect flag. It replaces single-channel energy blocks that relied on an external tap for the leaving sample and divided per term.

## Interface
- DATA_W, 16, signed sample width per channel
- CHANNELS, 4, number of independent channels sharing one in_valid
- WIN_LOG2, 4, log2 of window length N (N = 16 by default); WIN_LOG2 >= 1
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- clear  in  1  synchronous flush of windows, accumulators and pipeline
- in_valid  in  1  sample vector present on in_data this cycle
- in_data  in  CHANNELS*DATA_W  signed samples, channel c at bits [c*DATA_W +: DATA_W]
- threshold  in  2*DATA_W  unsigned power threshold, common to all channels
- out_valid  out  1  energy/detect updated this cycle (one-cycle pulse)
- energy  out  CHANNELS*2*DATA_W  unsigned window mean power, channel c at [c*2*DATA_W +: 2*DATA_W]
- detect  out  CHANNELS  channel c energy > threshold
- window_full  out  1  at least N samples accepted since last reset/clear

## Operation
- Per channel: sq = in_data_c * in_data_c, unsigned 2*DATA_W bits. (-2^(DATA_W-1))^2 = 2^(2*DATA_W-2) fits.
- Circular buffer: depth N per channel, stores squares (not samples); one shared write pointer, WIN_LOG2 bits, wraps N-1 -> 0.
- On accepted sample: read old_sq at the pointer, write new sq at the pointer, advance the pointer.
- old_sq is forced to 0 while fill count < N, so buffer contents after reset are don't-care and the memory needs no reset.
- Accumulator: unsigned 2*DATA_W+WIN_LOG2 bits; acc <= acc + sq - old_sq. Exact; never negative, never overflows.
- Mean: energy_c = acc_c >> WIN_LOG2, truncating. During fill the divisor stays N, so output ramps up.
- detect_c = (energy_c > threshold), strict, evaluated on the value being registered.
- Fill counter: saturates at N; window_full = (fill == N).
- Priority, highest first: reset, clear, in_valid.
- clear: acc, fill, pointer, stage-1 valid, energy, detect, window_full and out_valid all go to 0 on the next edge. An in_valid coinciding with clear is discarded.
- No in_valid: state holds; energy/detect hold their last values; out_valid stays 0.
- Channels are fully independent except for the shared valid, pointer and fill count.

## Timing
- Reset values: out_valid=0, energy=0, detect=0, window_full=0. Internally acc=0, fill=0, pointer=0, pipeline valid=0.
- Two-stage pipeline:
  - Stage 1 registers sq, old_sq and valid.
  - Stage 2 updates acc and registers energy, detect, window_full and out_valid.
- Latency: in_valid at edge k -> out_valid=1 with the corresponding result after edge k+2.
- Throughput: one vector per cycle, back-to-back in_valid allowed, no backpressure.
- window_full rises in the same cycle as the out_valid of the N-th accepted sample.
- Asynchronous reset mid-stream aborts in-flight samples; no out_valid is produced for them.
- threshold is sampled at stage 2. A change takes effect on the next out_valid.

## Test plan
- Fill (CHANNELS=4, WIN_LOG2=4, ch0 constant 100, 16 back-to-back samples): 16 out_valid pulses with ch0 energy k*10000>>4 for k=1..16, i.e. 625, 1250, …, 10000; window_full rises on pulse 16; out_valid trails in_valid by exactly 2 cycles.
- Decay/wrap (after full window of 100, feed 16 zeros then 8 values of 200): energy steps down by 625 to 0 on the 16th zero, then rises by 2500 per sample to 20000; exercises pointer wrap.
- Extremes (all channels -32768 for 20 samples): energy = 2^30 = 1073741824 from sample 16 on, internal acc = 2^34; a channel at +32767 reads 1073676289; no overflow or sign error.
- Gaps and threshold (in_valid 1-0-0-1 pattern, threshold=9999, ch1 constant 100): out_valid only for accepted samples; energy holds through gaps; detect[1] goes 1 exactly when energy reaches 10000; threshold=10000 keeps detect[1]=0.
- Clear/reset (clear asserted together with in_valid mid-window, then async reset asserted between clock edges mid-stream): all outputs 0 on the next edge; the coincident sample is discarded; after either event a refill of 100s reproduces the fill sequence from 625.
- Channel independence (ch0=100, ch1=0, ch2=-50, ch3 alternating ±1000): steady-state energies are 10000, 0, 2500 and 1000000 respectively.
